// File: rtl/get_stream_fsm.sv
// get_stream_fsm: GET command sub-FSM. It issues a key lookup and waits for
// the hit/miss response, aborting after TIMEOUT enabled cycles. On a hit it
// streams the stored value LSB-first in BEAT_W-wide beats over valid/ready,
// then reports completion to the controller with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en, enter       advance enable / start-restart (enter has priority)
//   lookup_req      key-store request, held until a response arrives
//   lookup_vld, hit key-store response and hit qualifier
//   value_in        stored value, captured on lookup_vld & hit
//   out_data/out_valid/out_ready/out_last  beat stream
//   done, op_succ, timeout_err             completion pulse and status
module get_stream_fsm #(
  parameter int unsigned VALUE_W = 64,
  parameter int unsigned BEAT_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               enter,
  output logic               lookup_req,
  input  logic               lookup_vld,
  input  logic               hit,
  input  logic [VALUE_W-1:0] value_in,
  output logic [BEAT_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               done,
  output logic               op_succ,
  output logic               timeout_err
);

  localparam int unsigned BEATS      = VALUE_W / BEAT_W;
  localparam int unsigned BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WAIT_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, SEND, DONE} state_t;

  state_t                         state_q, state_d;
  logic [BEATS-1:0][BEAT_W-1:0]   value_q, value_d;
  logic [BEAT_CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [WAIT_W-1:0]              wait_cnt_q, wait_cnt_d;
  logic                           succ_q, succ_d;
  logic                           tmo_q, tmo_d;
  logic                           act;
  logic                           is_last;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      value_q    <= '0;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
      succ_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      succ_q     <= succ_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    beat_cnt_d  = beat_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    succ_d      = succ_q;
    tmo_d       = tmo_q;
    lookup_req  = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    done        = 1'b0;
    op_succ     = 1'b0;
    timeout_err = 1'b0;

    // Handshake-style outputs only fire on a cycle that actually advances
    act     = en && !enter && rst_n;
    is_last = (beat_cnt_q == BEAT_CNT_W'(BEATS - 1));

    unique case (state_q)
      LOOKUP: lookup_req = act;
      SEND: begin
        out_valid = act;
        out_last  = act && is_last;
        // Data stays visible on stalls; it only depends on the beat pointer
        if (rst_n) out_data = value_q[beat_cnt_q];
      end
      DONE: begin
        done        = act;
        op_succ     = act && succ_q;
        timeout_err = act && tmo_q;
      end
      default: ;
    endcase

    if (enter) begin
      state_d    = LOOKUP;
      wait_cnt_d = '0;
      beat_cnt_d = '0;
      succ_d     = 1'b0;
      tmo_d      = 1'b0;
    end else if (en) begin
      unique case (state_q)
        IDLE: ;
        LOOKUP: begin
          // A response in the timeout cycle wins over the timeout
          if (lookup_vld) begin
            if (hit) begin
              value_d    = value_in;
              beat_cnt_d = '0;
              state_d    = SEND;
            end else begin
              succ_d  = 1'b0;
              state_d = DONE;
            end
          end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            tmo_d   = 1'b1;
            succ_d  = 1'b0;
            state_d = DONE;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (is_last) begin
              succ_d  = 1'b1;
              state_d = DONE;
            end else begin
              beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_get_stream_fsm.sv
// Directed bench for get_stream_fsm with hand-computed expected outputs.
module tb_get_stream_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        enter = 1'b0;
  logic        lookup_req;
  logic        lookup_vld = 1'b0;
  logic        hit = 1'b0;
  logic [63:0] value_in = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        done;
  logic        op_succ;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] V1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] V2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [21:0] IDLE_O = 22'h0;

  always #5 clk = ~clk;

  get_stream_fsm #(.VALUE_W(64), .BEAT_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .enter(enter),
    .lookup_req(lookup_req), .lookup_vld(lookup_vld), .hit(hit),
    .value_in(value_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .done(done),
    .op_succ(op_succ), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {lookup_req, out_valid, out_last, done, op_succ, timeout_err, out_data}
  function automatic logic [21:0] mk(input logic lr, input logic ov, input logic ol,
                                     input logic dn, input logic os, input logic te,
                                     input logic [15:0] d);
    return {lr, ov, ol, dn, os, te, d};
  endfunction

  function automatic logic [15:0] beat(input logic [63:0] v, input int i);
    logic [63:0] t;
    t = v >> (16 * i);
    return t[15:0];
  endfunction

  // Drive one cycle of inputs after the edge, then settle to the falling edge
  task automatic cyc(input logic r, input logic e, input logic ent, input logic v,
                     input logic h, input logic [63:0] val, input logic rdy);
    @(posedge clk);
    #1;
    rst_n = r; en = e; enter = ent; lookup_vld = v; hit = h;
    value_in = val; out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic expect_all(input string tag, input logic [21:0] exp);
    check(tag, 64'({lookup_req, out_valid, out_last, done, op_succ, timeout_err, out_data}),
          64'(exp));
  endtask

  task automatic expect_ctl(input string tag, input logic lr, input logic ov, input logic dn);
    check(tag, 64'({lookup_req, out_valid, done, op_succ, timeout_err}),
          64'({lr, ov, dn, 1'b0, 1'b0}));
  endtask

  // Four beats with out_ready=1, then the success done pulse, then IDLE
  task automatic drain(input string tag, input logic [63:0] v);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0, 0, '0, 1);
      expect_all($sformatf("%s_beat%0d", tag, i), mk(0, 1, i == 3, 0, 0, 0, beat(v, i)));
    end
    cyc(1, 1, 0, 0, 0, '0, 0);
    expect_all({tag, "_done"}, mk(0, 0, 0, 1, 1, 0, 16'h0));
    cyc(1, 1, 0, 0, 0, '0, 0);
    expect_all({tag, "_idle"}, IDLE_O);
  endtask

  initial begin
    int idx;
    // Reset with enter=1: reset wins, outputs 0 during and after
    cyc(0, 1, 1, 0, 0, '0, 0);
    expect_all("rst_during", IDLE_O);
    cyc(1, 1, 0, 0, 0, '0, 0);
    expect_all("rst_after", IDLE_O);

    // 1: hit on 3rd LOOKUP cycle, full-rate stream
    cyc(1, 1, 1, 0, 0, '0, 0);
    expect_all("t1_enter", IDLE_O);
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t1_lk1", mk(1, 0, 0, 0, 0, 0, 16'h0));
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t1_lk2", mk(1, 0, 0, 0, 0, 0, 16'h0));
    cyc(1, 1, 0, 1, 1, V1, 1);
    expect_all("t1_lk3", mk(1, 0, 0, 0, 0, 0, 16'h0));
    drain("t1", V1);

    // 2: out_ready pattern 1,0,0 repeating
    cyc(1, 1, 1, 0, 0, '0, 0);
    cyc(1, 1, 0, 0, 0, '0, 0);
    cyc(1, 1, 0, 0, 0, '0, 0);
    cyc(1, 1, 0, 1, 1, V1, 0);
    idx = 0;
    for (int k = 0; k < 30 && idx < 4; k++) begin
      logic r;
      r = ((k % 3) == 0);
      cyc(1, 1, 0, 0, 0, '0, r);
      expect_all($sformatf("t2_k%0d", k), mk(0, 1, idx == 3, 0, 0, 0, beat(V1, idx)));
      if (r) idx++;
    end
    cyc(1, 1, 0, 0, 0, '0, 0);
    expect_all("t2_done", mk(0, 0, 0, 1, 1, 0, 16'h0));

    // 3: miss in first LOOKUP cycle
    cyc(1, 1, 1, 0, 0, '0, 1);
    cyc(1, 1, 0, 1, 0, V1, 1);
    expect_all("t3_lk1", mk(1, 0, 0, 0, 0, 0, 16'h0));
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t3_done", mk(0, 0, 0, 1, 0, 0, 16'h0));
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t3_idle", IDLE_O);

    // 4a: timeout after 15 request cycles
    cyc(1, 1, 1, 0, 0, '0, 1);
    for (int i = 0; i < 15; i++) begin
      cyc(1, 1, 0, 0, 0, '0, 1);
      expect_all($sformatf("t4_req%0d", i), mk(1, 0, 0, 0, 0, 0, 16'h0));
    end
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t4_tmo", mk(0, 0, 0, 1, 0, 1, 16'h0));
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t4_idle", IDLE_O);

    // 4b: hit exactly in the 15th cycle beats the timeout
    cyc(1, 1, 1, 0, 0, '0, 1);
    for (int i = 0; i < 14; i++) cyc(1, 1, 0, 0, 0, '0, 1);
    cyc(1, 1, 0, 1, 1, V2, 1);
    expect_all("t4b_req15", mk(1, 0, 0, 0, 0, 0, 16'h0));
    drain("t4b", V2);

    // 5: restart mid-stream after 2 beats (also minimum hit latency)
    cyc(1, 1, 1, 0, 0, '0, 1);
    cyc(1, 1, 0, 1, 1, V1, 1);
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t5_b0", mk(0, 1, 0, 0, 0, 0, 16'h4444));
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t5_b1", mk(0, 1, 0, 0, 0, 0, 16'h3333));
    cyc(1, 1, 1, 0, 0, '0, 1);
    expect_ctl("t5_enter", 0, 0, 0);
    cyc(1, 1, 0, 1, 1, V2, 1);
    expect_all("t5_relookup", mk(1, 0, 0, 0, 0, 0, 16'h0));
    drain("t5", V2);

    // 6a: en=0 during LOOKUP freezes the timeout counter
    cyc(1, 1, 1, 0, 0, '0, 1);
    cyc(1, 1, 0, 0, 0, '0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, '0, 1);
      expect_ctl($sformatf("t6_lkoff%0d", i), 0, 0, 0);
    end
    for (int i = 0; i < 14; i++) begin
      cyc(1, 1, 0, 0, 0, '0, 1);
      expect_all($sformatf("t6_lk%0d", i), mk(1, 0, 0, 0, 0, 0, 16'h0));
    end
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t6_tmo", mk(0, 0, 0, 1, 0, 1, 16'h0));

    // 6b: en=0 during SEND and DONE
    cyc(1, 1, 1, 0, 0, '0, 1);
    cyc(1, 1, 0, 1, 1, V1, 1);
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t6_b0", mk(0, 1, 0, 0, 0, 0, 16'h4444));
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, '0, 1);
      expect_ctl($sformatf("t6_sdoff%0d", i), 0, 0, 0);
    end
    for (int i = 1; i < 4; i++) begin
      cyc(1, 1, 0, 0, 0, '0, 1);
      expect_all($sformatf("t6_b%0d", i), mk(0, 1, i == 3, 0, 0, 0, beat(V1, i)));
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, '0, 1);
      expect_ctl($sformatf("t6_dnoff%0d", i), 0, 0, 0);
    end
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t6_done", mk(0, 0, 0, 1, 1, 0, 16'h0));
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t6_idle", IDLE_O);

    // 6c: reset mid-SEND
    cyc(1, 1, 1, 0, 0, '0, 0);
    cyc(1, 1, 0, 1, 1, V2, 0);
    cyc(1, 1, 0, 0, 0, '0, 0);
    expect_all("t6_stall", mk(0, 1, 0, 0, 0, 0, 16'hDDDD));
    cyc(0, 1, 0, 0, 0, '0, 1);
    expect_all("t6_rst", IDLE_O);
    cyc(1, 1, 0, 0, 0, '0, 1);
    expect_all("t6_rst_idle", IDLE_O);
    cyc(1, 1, 0, 1, 1, V1, 1);
    expect_all("t6_rst_stay", IDLE_O);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
